booth_mult_arbiter: RTL and testbench
=====================================

// Module: booth_mult_arbiter
// PURPOSE
//  Shares one 12x12 Booth multiplier (fixed-latency pipelined, result_rdy strobe)
//  among N_REQ FFT butterfly requesters. Round-robin grant, registered issue,
//  in-order tag FIFO routes each product back to its requester. Sits between the
//  butterfly units and the single multiplier instance in the fft datapath.
// PARAMETERS
//  N_REQ    4   number of requesters (2..8); TW = $clog2(N_REQ) tag width
//  MAX_OUT  8   max multiplications in flight (tag FIFO depth, power of 2)
//  DW       12  operand width; product width PW = 2*DW
// PORTS
//  clk         in   1         system clock, all logic on rising edge
//  rst_n       in   1         asynchronous active-low reset
//  req         in   N_REQ     request i; held with operands until gnt[i]
//  req_a       in   N_REQ*DW  operand A, requester i at [i*DW +: DW]
//  req_b       in   N_REQ*DW  operand B, same packing
//  gnt         out  N_REQ     one-hot 1-cycle pulse: operands of i captured
//  rsp_vld     out  N_REQ     one-hot 1-cycle pulse: rsp_data belongs to i
//  rsp_data    out  PW        product, valid with any rsp_vld bit
//  mul_en      out  1         issue strobe to multiplier
//  mul_a       out  DW        multiplier operand 1
//  mul_b       out  DW        multiplier operand 2
//  mul_result  in   PW        multiplier product
//  mul_rdy     in   1         multiplier result strobe, in issue order
//  err_orphan  out  1         sticky: mul_rdy seen with empty tag FIFO
// BEHAVIOUR
//  Reset: gnt=0, rsp_vld=0, rsp_data=0, mul_en=0, mul_a=0, mul_b=0,
//   err_orphan=0, RR pointer=0, tag FIFO empty, outstanding count=0.
//  Arbitration (cycle n, combinational): eligible = req & ~gnt (requester granted
//   in current cycle is masked, preventing double issue of stale operands).
//   Search starts at ptr, wraps modulo N_REQ; first eligible index w wins.
//  Issue allowed when eligible!=0 and (cnt<MAX_OUT or mul_rdy in same cycle).
//  Cycle n+1 (registered): gnt[w]=1, mul_en=1, mul_a/mul_b = operands of w
//   sampled at n; tag w pushed to FIFO; ptr <= (w+1) mod N_REQ.
//   No issue: gnt=0, mul_en=0, mul_a/mul_b hold last value, ptr holds.
//  Throughput: 1 issue/cycle overall; max 1 issue per requester per 2 cycles.
//  Return: mul_rdy at cycle m pops FIFO head t; at m+1 rsp_vld[t]=1,
//   rsp_data=mul_result(m). rsp_data holds between strobes.
//  cnt: +1 on push, -1 on pop, unchanged on simultaneous push+pop; never
//   exceeds MAX_OUT. Full with no pop: requests wait, gnt stays 0.
//  mul_rdy with empty FIFO: result dropped, no rsp_vld, err_orphan<=1 (cleared
//   only by reset).
//  Reset mid-operation: FIFO and cnt cleared immediately; products still in
//   the multiplier pipeline return as orphans and set err_orphan.
//  Requester dropping req before gnt: withdrawn, no error.
// CONFIGURATION
//  MULT_ARB_STATS_EN defined: adds out port busy_cycles[31:0], reset 0,
//   +1 every cycle cnt!=0, saturates at 32'hFFFF_FFFF; plus out port
//   stall_cycles[31:0], +1 every cycle eligible!=0 but issue blocked by full.
//  Not defined: ports and counters absent; core behaviour identical.
// TESTING
//  1 Single req[0], a=12'd3, b=12'd5, mult latency L -> gnt[0] at n+1,
//    rsp_vld[0] at n+1+L+1, rsp_data=24'd15.
//  2 req=4'b1111 held, ptr=0 -> grants 0,1,2,3,0,... each requester 1 of every
//    4 issues; products routed to matching rsp_vld bit, in issue order.
//  3 Stall multiplier (mul_rdy=0) with continuous reqs -> exactly 8 gnt pulses,
//    then gnt=0; first mul_rdy -> one new grant same-cycle-allowed, cnt stays 8.
//  4 Signed operands a=12'hFFF(-1), b=12'h7FF -> rsp_data=24'hFFF801.
//  5 mul_rdy pulse with FIFO empty -> no rsp_vld, err_orphan=1 until rst_n=0.
//  6 Assert rst_n=0 with 3 in flight -> all outputs 0 asynchronously; after
//    release, 3 returning mul_rdy set err_orphan; new req[2] served normally.

Source files
------------

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: round-robin sharing of one pipelined multiplier among N_REQ requesters, in-order tag FIFO routes products back.
//   clk, rst_n            clock, asynchronous active-low reset
//   req/req_a/req_b       per-requester request and packed operands
//   gnt                   one-hot pulse: operands of that requester were captured
//   rsp_vld/rsp_data      one-hot pulse plus product for the owning requester
//   mul_en/mul_a/mul_b    issue strobe and operands to the multiplier
//   mul_result/mul_rdy    multiplier product and its in-order result strobe
//   err_orphan            sticky flag: a result arrived with no tag outstanding
//   MULT_ARB_STATS_EN     adds busy_cycles and stall_cycles counters
module booth_mult_arbiter #(
    parameter int N_REQ   = 4,
    parameter int MAX_OUT = 8,
    parameter int DW      = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*DW-1:0]   req_a,
    input  logic [N_REQ*DW-1:0]   req_b,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      rsp_vld,
    output logic [2*DW-1:0]       rsp_data,
    output logic                  mul_en,
    output logic [DW-1:0]         mul_a,
    output logic [DW-1:0]         mul_b,
    input  logic [2*DW-1:0]       mul_result,
    input  logic                  mul_rdy,
    output logic                  err_orphan
`ifdef MULT_ARB_STATS_EN
    ,
    output logic [31:0]           busy_cycles,
    output logic [31:0]           stall_cycles
`endif
);
    localparam int TW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int AW = $clog2(MAX_OUT);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(MAX_OUT);

    logic [TW-1:0]    ptr, w;
    logic [N_REQ-1:0] eligible, gnt_nxt, rsp_nxt;
    logic             found, empty, full, issue, pop;
    logic [TW-1:0]    tags [MAX_OUT];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt;
    int               idx;

    // Masking the requester granted this cycle keeps its stale operands from issuing twice.
    always_comb begin
        eligible = req & ~gnt;
        found    = 1'b0;
        w        = '0;
        idx      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                w     = TW'(idx);
            end
        end
    end

    assign empty = (cnt == '0);
    assign full  = (cnt == FULL_CNT);
    assign pop   = mul_rdy & ~empty;
    // A result leaving in the same cycle frees a slot, so a full FIFO may still accept.
    assign issue = found & (~full | mul_rdy);

    always_comb begin
        gnt_nxt = '0;
        rsp_nxt = '0;
        if (issue) gnt_nxt[w] = 1'b1;
        if (pop) rsp_nxt[tags[rd_ptr]] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt        <= '0;
            rsp_vld    <= '0;
            rsp_data   <= '0;
            mul_en     <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            err_orphan <= 1'b0;
            ptr        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
        end else begin
            gnt        <= gnt_nxt;
            rsp_vld    <= rsp_nxt;
            mul_en     <= issue;
            err_orphan <= err_orphan | (mul_rdy & empty);
            cnt        <= cnt + {{AW{1'b0}}, issue} - {{AW{1'b0}}, pop};
            if (issue) begin
                mul_a  <= req_a[w*DW +: DW];
                mul_b  <= req_b[w*DW +: DW];
                ptr    <= (w == TW'(N_REQ-1)) ? '0 : w + TW'(1);
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rsp_data <= mul_result;
                rd_ptr   <= rd_ptr + AW'(1);
            end
        end
    end

    // Tag storage needs no reset: only entries between rd_ptr and wr_ptr are ever read.
    always_ff @(posedge clk) begin
        if (issue) tags[wr_ptr] <= w;
    end

`ifdef MULT_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cycles  <= '0;
            stall_cycles <= '0;
        end else begin
            if (!empty && busy_cycles != 32'hFFFF_FFFF) busy_cycles <= busy_cycles + 32'd1;
            if (found && !issue && stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb_booth_mult_arbiter: directed checks of booth_mult_arbiter against a latency-L multiplier model.
module tb_booth_mult_arbiter;
    localparam int N = 4;
    localparam int DW = 12;
    localparam int L = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [N*DW-1:0]   req_a, req_b;
    logic [N-1:0]      gnt, rsp_vld;
    logic [2*DW-1:0]   rsp_data;
    logic              mul_en;
    logic [DW-1:0]     mul_a, mul_b;
    logic [2*DW-1:0]   mul_result = '0;
    logic              mul_rdy = 1'b0;
    logic              err_orphan;

    booth_mult_arbiter #(.N_REQ(N), .MAX_OUT(8), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .rsp_vld(rsp_vld), .rsp_data(rsp_data),
        .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result), .mul_rdy(mul_rdy), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n;

    logic hold = 1'b0;
    logic inject = 1'b0;
    int cyc = 0;
    logic [23:0] qd[$];
    int qt[$];
    logic signed [23:0] sa, sb;

    always @(negedge clk) begin
        cyc++;
        if (inject) begin
            mul_rdy = 1'b1;
            mul_result = 24'h123456;
        end else if (!hold && qd.size() > 0 && cyc - qt[0] >= L) begin
            mul_rdy = 1'b1;
            mul_result = qd.pop_front();
            void'(qt.pop_front());
        end else begin
            mul_rdy = 1'b0;
        end
        if (mul_en) begin
            sa = $signed(mul_a);
            sb = $signed(mul_b);
            qd.push_back(sa * sb);
            qt.push_back(cyc);
        end
    end

    logic [N-1:0] rv[$];
    logic [23:0]  rd[$];
    always @(negedge clk) begin
        if (rsp_vld != '0) begin
            rv.push_back(rsp_vld);
            rd.push_back(rsp_data);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        rv.delete();
        rd.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0;
        req_a = '0;
        req_b = '0;
        repeat (2) tick();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_rsp_vld", 32'(rsp_vld), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_mul_en", 32'(mul_en), 0);
        check("rst_mul_a", 32'(mul_a), 0);
        check("rst_err", 32'(err_orphan), 0);
        rst_n = 1'b1;
        tick();

        // single request, exact latency
        req_a[11:0] = 12'd3;
        req_b[11:0] = 12'd5;
        req = 4'b0001;
        tick();
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_mul_en", 32'(mul_en), 1);
        check("t1_mul_a", 32'(mul_a), 3);
        check("t1_mul_b", 32'(mul_b), 5);
        req = '0;
        tick();
        check("t1_gnt_pulse", 32'(gnt), 0);
        repeat (2) tick();
        check("t1_rsp_early", 32'(rsp_vld), 0);
        tick();
        check("t1_rsp_vld", 32'(rsp_vld), 32'h1);
        check("t1_rsp_data", 32'(rsp_data), 15);
        tick();
        check("t1_rsp_pulse", 32'(rsp_vld), 0);
        check("t1_rsp_hold", 32'(rsp_data), 15);

        // round robin with all requesters held
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_a[i*DW +: DW] = 12'(i + 1);
            req_b[i*DW +: DW] = 12'd10;
        end
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("t2_gnt%0d", k), 32'(gnt), 32'(1) << (k % 4));
        end
        req = '0;
        repeat (10) tick();
        check("t2_rsp_count", 32'(rv.size()), 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t2_rv%0d", k), 32'(rv[k]), 32'(1) << (k % 4));
            check($sformatf("t2_rd%0d", k), 32'(rd[k]), 32'((k % 4 + 1) * 10));
        end

        // stalled multiplier fills the tag FIFO
        do_reset();
        hold = 1'b1;
        req = 4'b1111;
        n = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (gnt != '0) n++;
        end
        check("t3_grants_full", 32'(n), 8);
        check("t3_gnt_blocked", 32'(gnt), 0);
        hold = 1'b0;
        tick();
        hold = 1'b1;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (gnt != '0) n++;
        end
        check("t3_grant_on_pop", 32'(n), 1);
        check("t3_one_rsp", 32'(rv.size()), 1);
        req = '0;
        hold = 1'b0;
        repeat (20) tick();
        check("t3_drained", 32'(rv.size()), 9);
        check("t3_no_orphan", 32'(err_orphan), 0);

        // signed operands
        do_reset();
        req_a[23:12] = 12'hFFF;
        req_b[23:12] = 12'h7FF;
        req = 4'b0010;
        tick();
        check("t4_gnt", 32'(gnt), 32'h2);
        req = '0;
        repeat (6) tick();
        check("t4_count", 32'(rv.size()), 1);
        check("t4_rv", 32'(rv[0]), 32'h2);
        check("t4_rd", 32'(rd[0]), 32'hFFF801);

        // orphan result
        do_reset();
        check("t5_err_clear", 32'(err_orphan), 0);
        inject = 1'b1;
        tick();
        inject = 1'b0;
        repeat (2) tick();
        check("t5_err_set", 32'(err_orphan), 1);
        check("t5_no_rsp", 32'(rv.size()), 0);
        repeat (5) tick();
        check("t5_err_sticky", 32'(err_orphan), 1);
        rst_n = 1'b0;
        #1;
        check("t5_err_rst", 32'(err_orphan), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // reset with three in flight
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_a[i*DW +: DW] = 12'(i + 2);
            req_b[i*DW +: DW] = 12'd5;
        end
        req = 4'b0111;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (gnt != '0) n++;
            req = req & ~gnt;
        end
        check("t6_inflight", 32'(n), 3);
        rst_n = 1'b0;
        #1;
        check("t6_gnt", 32'(gnt), 0);
        check("t6_rsp_vld", 32'(rsp_vld), 0);
        check("t6_rsp_data", 32'(rsp_data), 0);
        check("t6_mul_en", 32'(mul_en), 0);
        check("t6_mul_a", 32'(mul_a), 0);
        check("t6_mul_b", 32'(mul_b), 0);
        check("t6_err", 32'(err_orphan), 0);
        tick();
        rst_n = 1'b1;
        hold = 1'b0;
        repeat (8) tick();
        check("t6_orphan_no_rsp", 32'(rv.size()), 0);
        check("t6_orphan_err", 32'(err_orphan), 1);
        req_a[35:24] = 12'd7;
        req_b[35:24] = 12'd9;
        req = 4'b0100;
        tick();
        check("t6_gnt2", 32'(gnt), 32'h4);
        req = '0;
        repeat (6) tick();
        check("t6_count", 32'(rv.size()), 1);
        check("t6_rv", 32'(rv[0]), 32'h4);
        check("t6_rd", 32'(rd[0]), 63);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
